// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV64M multi-cycle sequencer: states, op classes,
// instruction codes and the decode used at accept.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MUL_LO,
        OP_MUL_HI_SS,
        OP_MUL_HI_SU,
        OP_MUL_HI_UU,
        OP_DIV,
        OP_REM
    } op_class_t;

    typedef struct packed {
        op_class_t cls;
        logic      is_signed;
        logic      is_word;
    } op_t;

    // M-extension instruction codes, mirrored from the core's instruction list
    localparam logic [6:0] I_MUL    = 7'd40;
    localparam logic [6:0] I_MULH   = 7'd41;
    localparam logic [6:0] I_MULHSU = 7'd42;
    localparam logic [6:0] I_MULHU  = 7'd43;
    localparam logic [6:0] I_MULW   = 7'd44;
    localparam logic [6:0] I_DIV    = 7'd45;
    localparam logic [6:0] I_DIVU   = 7'd46;
    localparam logic [6:0] I_REM    = 7'd47;
    localparam logic [6:0] I_REMU   = 7'd48;
    localparam logic [6:0] I_DIVW   = 7'd49;
    localparam logic [6:0] I_DIVUW  = 7'd50;
    localparam logic [6:0] I_REMW   = 7'd51;
    localparam logic [6:0] I_REMUW  = 7'd52;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic op_t decode_op(input logic [6:0] instr);
        op_t op;
        op.cls       = OP_NONE;
        op.is_signed = 1'b0;
        op.is_word   = 1'b0;
        case (instr)
            I_MUL:    op.cls = OP_MUL_LO;
            I_MULH:   op.cls = OP_MUL_HI_SS;
            I_MULHSU: op.cls = OP_MUL_HI_SU;
            I_MULHU:  op.cls = OP_MUL_HI_UU;
            I_MULW:   begin op.cls = OP_MUL_LO; op.is_word = 1'b1; end
            I_DIV:    begin op.cls = OP_DIV; op.is_signed = 1'b1; end
            I_DIVU:   op.cls = OP_DIV;
            I_REM:    begin op.cls = OP_REM; op.is_signed = 1'b1; end
            I_REMU:   op.cls = OP_REM;
            I_DIVW:   begin op.cls = OP_DIV; op.is_signed = 1'b1; op.is_word = 1'b1; end
            I_DIVUW:  begin op.cls = OP_DIV; op.is_word = 1'b1; end
            I_REMW:   begin op.cls = OP_REM; op.is_signed = 1'b1; op.is_word = 1'b1; end
            I_REMUW:  begin op.cls = OP_REM; op.is_word = 1'b1; end
            default:  op.cls = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor if it fits and shift the quotient bit in.
module muldiv_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted  = {rem, quo[XLEN-1]};
    assign trial    = shifted - {1'b0, divisor};
    // A borrow out of the top bit means the divisor did not fit
    assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/muldiv_seq.sv
// RV64M multi-cycle sequencer: timed multiply, radix-2 restoring divide, RISC-V corner
// cases, W-op sign extension. Optional MUL_DIV_EARLY_OUT_EN skips divides with |a| < |b|.
//
// state  | meaning
// IDLE   | ready to accept an op
// MUL    | waiting out the multiply pipeline latency
// DIV    | one restoring step per cycle
// FIX    | apply quotient/remainder signs and W sign extension
// DONE   | result held until writeback takes it
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      instr_in,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [6:0] MUL_TC = 7'(MUL_LAT - 1);

    state_t          state_q, state_d;
    logic [6:0]      count_q, count_d;
    op_t             op_q, op_d, dec_op, mul_op;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
    logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic [XLEN-1:0] dvd_ext, dvs_ext, dvd_mag, dvs_mag, corner_val;
    logic            dvd_neg, dvs_neg, dvs_zero, div_ovf, early_hit, is_div_op;
    logic [XLEN-1:0] step_rem, step_quo, mul_a, mul_b, mul_val;
    logic [XLEN-1:0] fix_quo, fix_rem, fix_sel, fix_val;
    logic            div_last;

    function automatic logic [63:0] mul_calc(input op_t op, input logic [63:0] a,
                                             input logic [63:0] b);
        logic [127:0] ea, eb, p;
        ea = (op.cls == OP_MUL_HI_SS || op.cls == OP_MUL_HI_SU) ? {{64{a[63]}}, a} : {64'b0, a};
        eb = (op.cls == OP_MUL_HI_SS) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = ea * eb;
        if (op.cls == OP_MUL_LO)
            return op.is_word ? sext32(p[31:0]) : p[63:0];
        return p[127:64];
    endfunction

    assign dec_op    = decode_op(instr_in);
    assign is_div_op = (dec_op.cls == OP_DIV) || (dec_op.cls == OP_REM);

    // Operand setup at accept: W ops use the low words, signed ops work on magnitudes
    always_comb begin
        dvd_ext = rs1;
        dvs_ext = rs2;
        if (dec_op.is_word) begin
            dvd_ext = dec_op.is_signed ? sext32(rs1[31:0]) : {32'b0, rs1[31:0]};
            dvs_ext = dec_op.is_signed ? sext32(rs2[31:0]) : {32'b0, rs2[31:0]};
        end
        dvd_neg  = dec_op.is_signed & dvd_ext[XLEN-1];
        dvs_neg  = dec_op.is_signed & dvs_ext[XLEN-1];
        dvd_mag  = dvd_neg ? -dvd_ext : dvd_ext;
        dvs_mag  = dvs_neg ? -dvs_ext : dvs_ext;
        dvs_zero = (dvs_ext == '0);
        div_ovf  = dec_op.is_signed && (dvs_ext == '1) &&
                   (dvd_ext == (dec_op.is_word ? sext32(32'h8000_0000) : {1'b1, 63'b0}));
        if (dvs_zero)
            corner_val = (dec_op.cls == OP_REM) ?
                         (dec_op.is_word ? sext32(rs1[31:0]) : rs1) : '1;
        else
            corner_val = (dec_op.cls == OP_REM) ? '0 : dvd_ext;
    end

`ifdef MUL_DIV_EARLY_OUT_EN
    assign early_hit = (dvd_mag < dvs_mag);
`else
    assign early_hit = 1'b0;
`endif

    assign mul_op  = (state_q == S_IDLE) ? dec_op : op_q;
    assign mul_a   = (state_q == S_IDLE) ? rs1 : quo_q;
    assign mul_b   = (state_q == S_IDLE) ? rs2 : dvs_q;
    assign mul_val = mul_calc(mul_op, mul_a, mul_b);

    muldiv_div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign fix_quo  = neg_quo_q ? -quo_q : quo_q;
    assign fix_rem  = neg_rem_q ? -rem_q : rem_q;
    assign fix_sel  = (op_q.cls == OP_REM) ? fix_rem : fix_quo;
    assign fix_val  = op_q.is_word ? sext32(fix_sel[31:0]) : fix_sel;
    assign div_last = (count_q == (op_q.is_word ? 7'd31 : 7'd63));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = dec_op;
                    if (dec_op.cls == OP_NONE) begin
                        result_d = 64'd1;
                        state_d  = S_DONE;
                    end else if (!is_div_op) begin
                        quo_d = rs1;
                        dvs_d = rs2;
                        if (MUL_LAT == 1) begin
                            result_d = mul_val;
                            state_d  = S_DONE;
                        end else begin
                            count_d = 7'd1;
                            state_d = S_MUL;
                        end
                    end else if (dvs_zero || div_ovf) begin
                        result_d = corner_val;
                        state_d  = S_DONE;
                    end else begin
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                        dvs_d     = dvs_mag;
                        if (early_hit) begin
                            rem_d   = dvd_mag;
                            quo_d   = '0;
                            state_d = S_FIX;
                        end else begin
                            rem_d   = '0;
                            quo_d   = dec_op.is_word ? {dvd_mag[31:0], 32'b0} : dvd_mag;
                            count_d = 7'd0;
                            state_d = S_DIV;
                        end
                    end
                end
            end
            S_MUL: begin
                if (count_q == MUL_TC) begin
                    result_d = mul_val;
                    state_d  = S_DONE;
                end else begin
                    count_d = count_q + 7'd1;
                end
            end
            S_DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (div_last)
                    state_d = S_FIX;
                else
                    count_d = count_q + 7'd1;
            end
            S_FIX: begin
                result_d = fix_val;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Redirect kills whatever is in flight, including an op offered this cycle
        if (flush) begin
            state_d = S_IDLE;
            count_d = 7'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

endmodule
